// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus types, constants and byte-lane helper
//
// Purpose : common definitions for the Avalon-MM wait-state memory and
//           future bus/cache stall logic.
// Contents: ram_state_t  - two-state access FSM encoding
//           WORD_BYTES   - bytes per 32-bit bus word
//           merge_lanes  - byte-lane merge of new data over an old word
package bus_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } ram_state_t;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] merged;
        merged = old_word;
        for (int lane = 0; lane < WORD_BYTES; lane++) begin
            if (lane_en[lane]) begin
                merged[8*lane +: 8] = new_word[8*lane +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter for bus stall timing
//
// Purpose : counts remaining stall cycles; stops at zero.
// Ports   : clk        - clock, rising edge
//           reset      - asynchronous active-low reset, clears the count
//           load       - load load_value (highest priority)
//           load_value - value to load
//           hold       - freeze the count this cycle
//           clear      - force the count to zero
//           zero       - count is zero
module wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         hold,
    input  logic         clear,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/avalon_wait_ram.sv
// rtl/avalon_wait_ram.sv - Avalon-MM word memory with programmable wait states
//
// Purpose : CPU-side slave memory that stalls each access for WAIT_STATES
//           cycles through waitrequest, supports byte-enabled writes, a
//           relocatable base address and a clocked preload port.
// Ports   : clk, reset (async active-low; memory contents survive reset)
//           address/read/write/writedata/byteenable - Avalon-MM request
//           waitrequest/readdata                    - Avalon-MM response
//           load_en/load_addr/load_data             - preload port
module avalon_wait_ram
    import bus_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    input  logic [3:0]               byteenable,
    output logic                     waitrequest,
    output logic [31:0]              readdata,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] SPAN     = 32'(WORD_BYTES * DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    ram_state_t state_q;
    ram_state_t state_d;

    logic [31:0]   mem_q [DEPTH];

    logic          req;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          accept;
    logic          commit;
    logic          cnt_load;
    logic          cnt_clear;
    logic          cnt_zero;
    logic          mem_we;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_word;
    logic          unused_offset_bits;

    // Address decode: wrap-around subtraction makes addresses below the
    // base appear huge, so a single compare covers both sides of the window.
    assign req      = read | write;
    assign offset   = address - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    wait_counter #(
        .W (4)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CNT_INIT),
        .hold       (load_en),
        .clear      (cnt_clear),
        .zero       (cnt_zero)
    );

    always_comb begin
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        state_d   = state_q;

        // A preload owns the array for the cycle, so the bus never completes.
        if (req && !load_en) begin
            if (state_q == IDLE) begin
                accept = (WAIT_STATES == 0);
            end else begin
                accept = cnt_zero;
            end
        end

        case (state_q)
            IDLE: begin
                if (req && !load_en && (WAIT_STATES != 0)) begin
                    cnt_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    // Master abandoned the access: nothing commits.
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else if (!load_en && cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response path. A simultaneous read+write is a write, so no read data.
    always_comb begin
        waitrequest = req && !accept;
        readdata    = '0;
        if (accept && read && !write && in_range) begin
            readdata = mem_q[word_idx];
        end
    end

    // Write path: preload writes the full word, bus writes merge lanes.
    always_comb begin
        commit  = accept && write && in_range;
        mem_we  = load_en || commit;
        wr_idx  = load_en ? load_addr : word_idx;
        wr_word = load_en ? load_data
                          : merge_lanes(mem_q[word_idx], writedata, byteenable);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

endmodule

// File: doc/avalon_wait_ram.md
# avalon_wait_ram

Word-organised Avalon-MM slave memory that sits directly downstream of `top_level_cpu` on its data/instruction bus and replaces the zero-latency bench memory in directed CPU tests. It adds a programmable number of wait states driven through `waitrequest`, honours `byteenable` on writes, maps a configurable base address, and provides a synchronous clocked preload port for program images. The purpose is to exercise the CPU's stall handling under realistic bus latency.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'hBFC0_0000: byte address of word 0.
- `WAIT_STATES`, 2: stall cycles per access, 0–15.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low; clears FSM and counter, not memory contents.
- `address` in 32: byte address from the CPU; bits [1:0] ignored.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `byteenable` in 4: bit i enables byte lane bits [8i+7:8i].
- `waitrequest` out 1: high stalls the master. Reset value 0.
- `readdata` out 32: read data, valid in the accept cycle. Reset value 0.
- `load_en` in 1: preload write strobe.
- `load_addr` in log2(DEPTH): preload word index.
- `load_data` in 32: preload word.

## Operation
- `req = read | write`. The word index is `(address - BASE_ADDR) >> 2`. An access is in range when `address - BASE_ADDR < 4*DEPTH`.
- FSM states:
  - IDLE:
    - If `req && WAIT_STATES==0`, accept in this cycle.
    - If `req && WAIT_STATES>0`, assert `waitrequest`, load `cnt = WAIT_STATES-1`, and go to BUSY.
  - BUSY:
    - While `cnt != 0`, hold `waitrequest` high and decrement `cnt`.
    - When `cnt == 0`, drive `waitrequest` low, accept, and return to IDLE.
- Accept cycle:
  - Reads drive `readdata` combinationally from the array.
  - Writes update enabled lanes at the closing clock edge.
- Out-of-range: reads return 32'h0 and writes are dropped. Wait-state timing is unchanged.
- `read` and `write` both high: treated as a write, and `readdata` returns 0.
- Request dropped while in BUSY: return to IDLE with no commit. `waitrequest` follows `req` combinationally, so it is low the moment `req` falls.
- `load_en` has priority over the bus:
  - `waitrequest` is forced high and `cnt` is held.
  - The word at `load_addr` is fully written at the edge.
- `readdata` is 0 whenever not in an accept cycle.

## Timing
- Stall cycles per access = WAIT_STATES exactly. Total access time = WAIT_STATES + 1 cycles.
- Back-to-back requests: the cycle after an accept is in IDLE and starts a fresh count. There is no pipelining and only one outstanding access.
- `waitrequest` is combinational: `req && !(accept condition)`. It is 0 when `req` is low.
- Reset mid-access:
  - FSM goes to IDLE and `cnt` goes to 0 immediately.
  - No write commits.
  - Array contents are preserved.
- A write followed by a read of the same word returns the new data; the write has committed at the edge.

## Structure
- Shared package `bus_pkg`:
  - `typedef enum logic {IDLE, BUSY} ram_state_t`.
  - A byte-lane merge function.
  - `WORD_BYTES = 4`.
- Sub-module `wait_counter`: loadable down-counter with `load`, `hold`, and `zero` outputs, reusable for later cache/bus stalls.
- Top: FSM, address decode, and a `DEPTH×32` array with per-lane write enables.

## Test plan
- Reset low mid-BUSY with a pending write of 32'hDEAD_BEEF: no commit, `waitrequest` drops, and a subsequent read returns the preloaded value.
- Preload 32'h2402_0010 at index 1 with WAIT_STATES=2, then read `address=BFC0_0004`:
  - `waitrequest` is high for exactly 2 cycles.
  - `readdata=32'h2402_0010` in cycle 3.
- Write 32'hAABB_CCDD with `byteenable=4'b0101` over 32'h1111_1111: readback is 32'h11BB_11DD.
- WAIT_STATES=0 read: `waitrequest` is never high, and data is valid in the request cycle.
- Read at `BASE_ADDR + 4*DEPTH`: returns 0 after the normal stall. A write there leaves the whole array unchanged.
- `load_en` asserted during a bus read: `waitrequest` stays high through the load cycles, then the read completes with the remaining stall count.
- Full CPU run: the branch/link program ends with `register_v0 = 32'hA0` under both WAIT_STATES=3 and WAIT_STATES=0.
